baud_gen_frac: RTL and testbench
================================

# baud_gen_frac

Parametrised baud-rate generator for the UART, the successor to the fixed 16x generator. It divides the system clock into an oversample tick, with an optional fractional divisor, and derives two independent bit-rate strobes from it. The TX strobe is free-running. The RX strobe is phase-aligned to the start bit, so the receiver samples mid-bit. It sits between the UART register file (divisor, fraction, enable) and the TX/RX shift engines.

## Interface
- `DIV_W`, default 16: width of the integer divisor.
- `FRAC_W`, default 4: width of the fractional divisor and its accumulator.
- `OSR`, default 16: oversample ratio, i.e. sample ticks per bit. Legal range 4..256, even values only.
- `clk` input, 1: single system clock; all logic on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `baud_en` input, 1: generator enable; low holds all counters cleared.
- `divisor` input, DIV_W: integer sample period minus one, in clk cycles.
- `frac` input, FRAC_W: fractional part of the sample period, in units of 1/2^FRAC_W cycle.
- `rx_restart` input, 1: one-cycle pulse from the RX start-bit detector; realigns the RX bit phase.
- `sample_tick` output, 1: oversample strobe, one clk cycle wide.
- `tx_bit_tick` output, 1: TX bit strobe, one cycle wide, once per OSR sample ticks.
- `rx_mid_tick` output, 1: RX mid-bit strobe, one cycle wide, once per OSR sample ticks, phase set by `rx_restart`.

## Operation
- **Prescaler.** `pre_cnt` (DIV_W bits) counts up while `baud_en` is high.
  - It wraps to 0 when `pre_cnt >= limit`; on that cycle `sample_tick` is registered high for the next cycle.
  - `limit` is `divisor`, or `divisor + 1` when the extend flag is set.
  - The compare is `>=`, not `==`. If `divisor` is lowered below the current count, the prescaler wraps on the next cycle and never runs to 2^DIV_W.
- **Divisor 0.** With extend clear, `sample_tick` is high every cycle.
- **Fractional accumulator** (only with the macro, see Configuration).
  - On each prescaler wrap, `acc <= acc + frac`, modulo 2^FRAC_W.
  - The carry-out is registered as `extend`, which lengthens the next sample period by exactly one cycle.
  - Average period is `divisor + 1 + frac / 2^FRAC_W` cycles.
- **TX phase.** `tx_cnt` (width `$clog2(OSR)`) increments on each `sample_tick` and wraps from OSR-1 to 0.
  - `tx_bit_tick` is registered high for the cycle after the `sample_tick` on which `tx_cnt == OSR-1`.
- **RX phase.** `rx_cnt` (same width) increments on each `sample_tick`, modulo OSR.
  - `rx_mid_tick` is registered high for the cycle after the `sample_tick` on which `rx_cnt == OSR/2 - 1`.
  - `rx_restart` forces `rx_cnt <= 0`. It does not touch `pre_cnt`, `acc` or `tx_cnt`.
- **`rx_restart` coincident with `sample_tick`.** Restart wins: `rx_cnt` becomes 0, not 1, and no `rx_mid_tick` is generated from that tick.
- **`baud_en` low.** `pre_cnt`, `acc`, `extend`, `tx_cnt` and `rx_cnt` are cleared, and all outputs are 0 from the next cycle. `rx_restart` is ignored while disabled.
  - When `baud_en` rises, the first `sample_tick` appears `divisor + 1` cycles later.
- **Register changes.** `divisor` and `frac` are sampled live; no shadow registers. A change affects the current period's compare and the next accumulate.
- **Reset.** All counters, `acc`, `extend` and all three outputs reset to 0.

## Timing
- `sample_tick`: one cycle wide, period `divisor + 1` cycles, or `divisor + 2` when extended.
- `tx_bit_tick`: period OSR sample periods. It lags the causing `sample_tick` by exactly one clk cycle, so it never coincides with it.
- `rx_mid_tick`: first pulse one clk cycle after the (OSR/2)-th `sample_tick` following `rx_restart`, then every OSR sample ticks.
- **Reset mid-operation.** Outputs drop asynchronously when `rst_n` falls. Counting restarts from 0 on the first edge after release, provided `baud_en` is high.

## Configuration
- `BAUD_FRAC_EN` defined: the fractional accumulator and `extend` flag are built.
- `BAUD_FRAC_EN` undefined: `frac` is kept as a port but ignored, `acc` and `extend` are not instantiated, and `extend` is treated as 0. The sample period is exactly `divisor + 1` cycles.

## Test plan
- **Integer division.** OSR=16, `divisor`=3, `frac`=0, `baud_en`=1 → `sample_tick` every 4 cycles; `tx_bit_tick` every 64 cycles, one cycle after every 16th tick.
- **Fractional division** (`BAUD_FRAC_EN`, FRAC_W=4). `divisor`=3, `frac`=8 → sample periods alternate 4 and 5 cycles; 16 ticks in exactly 72 cycles. Same stimulus without the macro → 64 cycles.
- **RX realignment.** Pulse `rx_restart` at an arbitrary phase → `rx_mid_tick` one cycle after the 8th following `sample_tick`, then every 16 ticks. `tx_bit_tick` cadence is unchanged.
- **Simultaneous events.** `rx_restart` in the same cycle as `sample_tick` → `rx_cnt` reads 0 and the next `rx_mid_tick` comes 8 ticks later.
- **Divisor shrink.** With `pre_cnt`=100, change `divisor` from 200 to 10 → wrap on the next cycle; subsequent period 11 cycles; no 65536-cycle stall.
- **Enable and reset abort.** Drop `baud_en` mid-bit → all outputs 0 next cycle; re-enable → first `sample_tick` after `divisor + 1` cycles. Assert `rst_n`=0 mid-bit → outputs 0 immediately.

Source files
------------

// File: rtl/baud_gen_frac.sv
// ---------------------------------------------------------------------------
// baud_gen_frac
//
// Purpose:
//   Baud-rate generator for the UART. A prescaler divides clk into an
//   oversample strobe (sample_tick). Two independent OSR-modulo phase counters
//   run from that strobe:
//     - TX phase: free-running, gives one tx_bit_tick per OSR sample ticks.
//     - RX phase: realigned by rx_restart, so rx_mid_tick lands mid-bit.
//   Optional fractional divisor: a FRAC_W-bit accumulator adds frac on each
//   prescaler wrap. Its carry lengthens the following sample period by one
//   cycle.
//
// Configuration macro:
//   BAUD_FRAC_EN - builds the fractional accumulator and extend flag. When
//                  it is undefined, frac is ignored and every sample period
//                  is exactly divisor + 1 cycles.
//
// Parameters:
//   DIV_W  - integer divisor width (default 16)
//   FRAC_W - fractional divisor / accumulator width (default 4)
//   OSR    - sample ticks per bit, even, 4..256 (default 16)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   baud_en     in   enable; low clears all counters and outputs
//   divisor     in   sample period minus one, in clk cycles (live)
//   frac        in   fractional sample period, 1/2^FRAC_W cycle units (live)
//   rx_restart  in   one-cycle pulse, realigns the RX bit phase
//   sample_tick out  one-cycle oversample strobe
//   tx_bit_tick out  one-cycle TX bit strobe, every OSR sample ticks
//   rx_mid_tick out  one-cycle RX mid-bit strobe, every OSR sample ticks
// ---------------------------------------------------------------------------
module baud_gen_frac #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4,
    parameter int unsigned OSR    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              baud_en,
    input  logic [DIV_W-1:0]  divisor,
    input  logic [FRAC_W-1:0] frac,
    input  logic              rx_restart,
    output logic              sample_tick,
    output logic              tx_bit_tick,
    output logic              rx_mid_tick
);

    localparam int unsigned     CNT_W   = $clog2(OSR);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(OSR - 1);
    localparam logic [CNT_W-1:0] RX_MID  = CNT_W'(OSR / 2 - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0] tx_cnt_q,  tx_cnt_d;
    logic [CNT_W-1:0] rx_cnt_q,  rx_cnt_d;
    logic             sample_tick_q, sample_tick_d;
    logic             tx_bit_tick_q, tx_bit_tick_d;
    logic             rx_mid_tick_q, rx_mid_tick_d;

    logic             extend;
    logic [DIV_W:0]   limit;
    logic             pre_wrap;

    // -----------------------------------------------------------------------
    // Fractional accumulator
    // -----------------------------------------------------------------------
`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              extend_q, extend_d;

    always_comb begin
        acc_d    = acc_q;
        extend_d = extend_q;
        if (!baud_en) begin
            acc_d    = '0;
            extend_d = 1'b0;
        end else if (pre_wrap) begin
            // Carry out of the modulo-2^FRAC_W add stretches the next period.
            {extend_d, acc_d} = {1'b0, acc_q} + {1'b0, frac};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            extend_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            extend_q <= extend_d;
        end
    end

    assign extend = extend_q;
`else
    logic unused_frac;

    assign unused_frac = ^frac;
    assign extend      = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Prescaler
    // -----------------------------------------------------------------------
    // The >= compare makes a live divisor decrease take effect on the next
    // cycle instead of running the counter round 2^DIV_W. The all-ones term
    // only matters when divisor is all-ones with extend set: the limit then
    // exceeds the counter range, and the counter wraps at its top instead of
    // overflowing silently without a tick.
    always_comb begin
        limit    = {1'b0, divisor} + {{DIV_W{1'b0}}, extend};
        pre_wrap = ({1'b0, pre_cnt_q} >= limit) || (&pre_cnt_q);

        pre_cnt_d     = pre_cnt_q + 1'b1;
        sample_tick_d = 1'b0;
        if (!baud_en) begin
            pre_cnt_d = '0;
        end else if (pre_wrap) begin
            pre_cnt_d     = '0;
            sample_tick_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // TX phase: free-running modulo-OSR count of sample ticks
    // -----------------------------------------------------------------------
    always_comb begin
        tx_cnt_d      = tx_cnt_q;
        tx_bit_tick_d = 1'b0;
        if (!baud_en) begin
            tx_cnt_d = '0;
        end else if (sample_tick_q) begin
            if (tx_cnt_q == TX_LAST) begin
                tx_cnt_d      = '0;
                tx_bit_tick_d = 1'b1;
            end else begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // RX phase: modulo-OSR count, realigned by rx_restart
    // -----------------------------------------------------------------------
    // A restart in the same cycle as a sample tick discards that tick, so the
    // count restarts at 0 and that tick can never produce a mid-bit strobe.
    always_comb begin
        rx_cnt_d      = rx_cnt_q;
        rx_mid_tick_d = 1'b0;
        if (!baud_en) begin
            rx_cnt_d = '0;
        end else if (rx_restart) begin
            rx_cnt_d = '0;
        end else if (sample_tick_q) begin
            rx_mid_tick_d = (rx_cnt_q == RX_MID);
            if (rx_cnt_q == TX_LAST) begin
                rx_cnt_d = '0;
            end else begin
                rx_cnt_d = rx_cnt_q + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q     <= '0;
            tx_cnt_q      <= '0;
            rx_cnt_q      <= '0;
            sample_tick_q <= 1'b0;
            tx_bit_tick_q <= 1'b0;
            rx_mid_tick_q <= 1'b0;
        end else begin
            pre_cnt_q     <= pre_cnt_d;
            tx_cnt_q      <= tx_cnt_d;
            rx_cnt_q      <= rx_cnt_d;
            sample_tick_q <= sample_tick_d;
            tx_bit_tick_q <= tx_bit_tick_d;
            rx_mid_tick_q <= rx_mid_tick_d;
        end
    end

    assign sample_tick = sample_tick_q;
    assign tx_bit_tick = tx_bit_tick_q;
    assign rx_mid_tick = rx_mid_tick_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// ---------------------------------------------------------------------------
// tb_baud_gen_frac
//
// Self-checking bench for baud_gen_frac (DIV_W=16, FRAC_W=4, OSR=16).
// Directed sections measure tick spacing in clk cycles. A randomized section
// compares every output on every cycle against an event-level model. The
// model keeps the elapsed cycles since the last sample tick and integer tick
// counts modulo OSR. Honours BAUD_FRAC_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_baud_gen_frac;

    localparam int unsigned DIV_W  = 16;
    localparam int unsigned FRAC_W = 4;
    localparam int unsigned OSR    = 16;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              baud_en    = 1'b0;
    logic              rx_restart = 1'b0;
    logic [DIV_W-1:0]  divisor    = '0;
    logic [FRAC_W-1:0] frac       = '0;
    logic              sample_tick, tx_bit_tick, rx_mid_tick;

    int checks   = 0;
    int failures = 0;

    baud_gen_frac #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W),
        .OSR    (OSR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_en     (baud_en),
        .divisor     (divisor),
        .frac        (frac),
        .rx_restart  (rx_restart),
        .sample_tick (sample_tick),
        .tx_bit_tick (tx_bit_tick),
        .rx_mid_tick (rx_mid_tick)
    );

    always #5 clk = ~clk;

    // Value of sample_tick during the previous clk cycle.
    logic st_last = 1'b0;
    always @(posedge clk) st_last <= sample_tick;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    int unsigned m_elapsed = 0;
    int unsigned m_acc     = 0;
    int unsigned m_ext     = 0;
    int unsigned m_ticks_tx = 0;
    int unsigned m_ticks_rx = 0;
    bit          m_st = 0, m_tx = 0, m_rx = 0;

    always @(posedge clk or negedge rst_n) begin
        bit          wrap;
        bit          n_tx, n_rx;
        int unsigned sum;
        if (!rst_n || !baud_en) begin
            m_elapsed  = 0; m_acc = 0; m_ext = 0;
            m_ticks_tx = 0; m_ticks_rx = 0;
            m_st = 0; m_tx = 0; m_rx = 0;
        end else begin
            wrap = (m_elapsed >= int'(divisor) + m_ext) || (m_elapsed == (1 << DIV_W) - 1);
            n_tx = m_st && (m_ticks_tx == OSR - 1);
            n_rx = m_st && !rx_restart && (m_ticks_rx == OSR / 2 - 1);
            if (m_st) m_ticks_tx = (m_ticks_tx + 1) % OSR;
            if (rx_restart)  m_ticks_rx = 0;
            else if (m_st)   m_ticks_rx = (m_ticks_rx + 1) % OSR;
            if (wrap) begin
`ifdef BAUD_FRAC_EN
                sum   = m_acc + int'(frac);
                m_ext = sum / (1 << FRAC_W);
                m_acc = sum % (1 << FRAC_W);
`else
                sum   = 0;
`endif
                m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
            m_st = wrap;
            m_tx = n_tx;
            m_rx = n_rx;
        end
    end

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic logic sig(input int sel);
        case (sel)
            0:       return sample_tick;
            1:       return tx_bit_tick;
            default: return rx_mid_tick;
        endcase
    endfunction

    // Cycles until the selected strobe is seen (inclusive), bounded.
    task automatic wait_for(input string tag, input int sel, input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(sel) && n < max);
        check_eq({tag, "_seen"}, 32'(sig(sel)), 32'd1);
    endtask

    // Cycles spanned by k sample ticks, starting just after a tick.
    task automatic cycles_for_ticks(input int k, input int max, output int n);
        int seen = 0;
        n = 0;
        while (seen < k && n < max) begin
            @(negedge clk);
            n++;
            if (sample_tick) seen++;
        end
    endtask

    // Sample ticks strictly before the next rx_mid_tick, bounded.
    task automatic ticks_to_mid(input string tag, input int max, output int ticks);
        int n = 0;
        ticks = 0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (rx_mid_tick) break;
            if (sample_tick) ticks++;
        end
        check_eq({tag, "_seen"}, 32'(rx_mid_tick), 32'd1);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int n, t, off_cycles;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_sample_tick", 32'(sample_tick), 32'd0);
        check_eq("rst_tx_bit_tick", 32'(tx_bit_tick), 32'd0);
        check_eq("rst_rx_mid_tick", 32'(rx_mid_tick), 32'd0);
        rst_n = 1'b1;

        // Integer division, divisor=3
        @(negedge clk);
        divisor = 16'd3;
        frac    = '0;
        baud_en = 1'b1;
        wait_for("en_first", 0, 20, n);
        check_eq("en_first_latency", 32'(n), 32'd4);
        wait_for("int", 0, 20, n);
        check_eq("int_period", 32'(n), 32'd4);
        wait_for("txsync", 1, 200, n);
        check_eq("tx_lag_prev_tick", 32'(st_last), 32'd1);
        check_eq("tx_not_coincident", 32'(sample_tick), 32'd0);
        wait_for("tx", 1, 200, n);
        check_eq("tx_period", 32'(n), 32'd64);

        // Fractional division, divisor=3 frac=8
        baud_en = 1'b0;
        @(negedge clk);
        frac    = 4'd8;
        baud_en = 1'b1;
        wait_for("frac_first", 0, 20, n);
        cycles_for_ticks(16, 200, n);
`ifdef BAUD_FRAC_EN
        check_eq("frac_16_ticks", 32'(n), 32'd72);
`else
        check_eq("frac_16_ticks", 32'(n), 32'd64);
`endif

        // RX realignment at a non-tick phase
        baud_en = 1'b0;
        @(negedge clk);
        frac    = '0;
        baud_en = 1'b1;
        repeat (22) @(negedge clk);
        while (sample_tick) @(negedge clk);
        rx_restart = 1'b1;
        @(negedge clk);
        rx_restart = 1'b0;
        if (sample_tick) t = 1; else t = 0;
        ticks_to_mid("rx_align", 200, n);
        check_eq("rx_align_ticks", 32'(n + t), 32'd8);
        ticks_to_mid("rx_repeat", 400, n);
        check_eq("rx_repeat_ticks", 32'(n), 32'd16);
        wait_for("tx_after_rx", 1, 200, n);
        wait_for("tx_after_rx2", 1, 200, n);
        check_eq("tx_period_after_rx", 32'(n), 32'd64);

        // rx_restart coincident with sample_tick
        wait_for("coinc_sync", 0, 20, n);
        rx_restart = 1'b1;
        @(negedge clk);
        rx_restart = 1'b0;
        ticks_to_mid("rx_coinc", 200, n);
        check_eq("rx_coinc_ticks", 32'(n), 32'd8);

        // Divisor shrink from 200 to 10 at pre_cnt=100
        baud_en = 1'b0;
        @(negedge clk);
        divisor = 16'd200;
        baud_en = 1'b1;
        wait_for("shrink_sync", 0, 300, n);
        check_eq("div200_first", 32'(n), 32'd201);
        repeat (100) @(negedge clk);
        divisor = 16'd10;
        wait_for("shrink_wrap", 0, 20, n);
        check_eq("shrink_wrap_cycles", 32'(n), 32'd1);
        wait_for("shrink_next", 0, 50, n);
        check_eq("shrink_period", 32'(n), 32'd11);

        // Enable drop just before a tick is due
        divisor = 16'd3;
        wait_for("endrop_sync", 0, 20, n);
        wait_for("endrop_sync2", 0, 20, n);
        repeat (3) @(negedge clk);
        baud_en = 1'b0;
        @(negedge clk);
        check_eq("dis_sample_tick", 32'(sample_tick), 32'd0);
        check_eq("dis_tx_bit_tick", 32'(tx_bit_tick), 32'd0);
        check_eq("dis_rx_mid_tick", 32'(rx_mid_tick), 32'd0);
        rx_restart = 1'b1;
        repeat (5) @(negedge clk);
        rx_restart = 1'b0;
        divisor = 16'd5;
        baud_en = 1'b1;
        wait_for("reen", 0, 30, n);
        check_eq("reen_latency", 32'(n), 32'd6);

        // Asynchronous reset while sample_tick is high
        wait_for("rst_sync", 0, 30, n);
        #1 rst_n = 1'b0;
        #1 check_eq("async_rst_tick", 32'(sample_tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_for("post_rst", 0, 30, n);
        check_eq("post_rst_latency", 32'(n), 32'd6);

        // Randomized run against the model
        off_cycles = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            check_eq("rnd_sample_tick", 32'(sample_tick), 32'(m_st));
            check_eq("rnd_tx_bit_tick", 32'(tx_bit_tick), 32'(m_tx));
            check_eq("rnd_rx_mid_tick", 32'(rx_mid_tick), 32'(m_rx));
            if ($urandom_range(0, 149) == 0) divisor = DIV_W'($urandom_range(0, 6));
            if ($urandom_range(0, 99) == 0)  frac    = FRAC_W'($urandom);
            rx_restart = ($urandom_range(0, 39) == 0);
            if (off_cycles > 0) begin
                off_cycles--;
                baud_en = (off_cycles == 0);
            end else if ($urandom_range(0, 299) == 0) begin
                off_cycles = $urandom_range(1, 4);
                baud_en    = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
